// File: rtl/output_buffer_if.sv
// Write-master side of output_buffer: burst request, completion and the beat stream.
// Handshake: a beat moves on a rising clk edge where tvalid && tready; within a burst tvalid
// stays high until the last beat moves, and tdata holds while tvalid && !tready.
interface output_buffer_if #(
  parameter int DATA_WIDTH = 512
);
  logic                  wmst_req;
  logic                  wmst_done;
  logic [63:0]           addr_offset;
  logic [63:0]           xfer_size;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output wmst_req, addr_offset, xfer_size, tdata, tvalid,
    input  wmst_done, tready
  );

  modport slave (
    input  wmst_req, addr_offset, xfer_size, tdata, tvalid,
    output wmst_done, tready
  );
endinterface

// File: rtl/output_buffer.sv
// Result-word FIFO drained to the AXI write master as full bursts, plus a flushed tail burst on end_conv.
// Optional OUTPUT_BUFFER_STAT_EN adds the wr_bytes byte counter port.
module output_buffer #(
  parameter int DATA_WIDTH        = 512,
  parameter int DATA_WIDTH_BYTE   = DATA_WIDTH/8,
  parameter int FIFO_ADDR_WIDTH   = 7,
  parameter int BURST_LENGTH      = 64,
  parameter int BURST_LENGTH_BYTE = DATA_WIDTH_BYTE*BURST_LENGTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_req,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  stall,
  input  logic                  op_start,
  input  logic                  end_conv,
  output logic                  conv_done,
  input  logic [63:0]           addr_base,
  output logic [1:0]            dbg_state,
`ifdef OUTPUT_BUFFER_STAT_EN
  output logic [63:0]           wr_bytes,
`endif
  output_buffer_if.master       wm
);

  localparam int             DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int             CW    = FIFO_ADDR_WIDTH + 1;
  localparam logic [CW-1:0]  BL_C  = CW'(BURST_LENGTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         wr_ptr, rd_ptr, cnt;
  logic [CW-1:0]         beats_q, beats_n, beat_cnt;
  logic                  full, push_en, pop_en, tvalid_c;
  logic                  start_burst, conv_done_c, flush_pend;
  logic [63:0]           base_q, addr_cnt, addr_offset_q, xfer_size_q;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  assign cnt     = wr_ptr - rd_ptr;
  assign full    = (cnt == CW'(DEPTH));
  assign stall   = full;
  assign push_en = push_req & ~full;
  assign pop_en  = tvalid_c & wm.tready;

  assign tvalid_c       = (state == S_XFER) && (beat_cnt < beats_q);
  assign wm.tvalid      = tvalid_c;
  assign wm.tdata       = mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]];
  assign wm.wmst_req    = (state == S_REQ);
  assign wm.addr_offset = addr_offset_q;
  assign wm.xfer_size   = xfer_size_q;
  assign conv_done      = conv_done_c;
  assign dbg_state      = state;

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= i_data;
  end

  always_comb begin
    state_n     = state;
    beats_n     = beats_q;
    start_burst = 1'b0;
    conv_done_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (cnt >= BL_C) begin
          beats_n     = BL_C;
          start_burst = 1'b1;
          state_n     = S_REQ;
        end else if (flush_pend && (cnt != '0)) begin
          // Tail burst length is frozen here; later pushes wait for a later burst.
          beats_n     = cnt;
          start_burst = 1'b1;
          state_n     = S_REQ;
        end else if (flush_pend) begin
          conv_done_c = 1'b1;
        end
      end
      S_REQ:   state_n = S_XFER;
      S_XFER:  if (pop_en && (beat_cnt == beats_q - CW'(1))) state_n = S_WAIT;
      S_WAIT:  if (wm.wmst_done) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beats_q  <= BL_C;
      beat_cnt <= '0;
    end else begin
      state   <= state_n;
      beats_q <= beats_n;
      if (push_en) wr_ptr <= wr_ptr + CW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + CW'(1);
      if (state == S_REQ)  beat_cnt <= '0;
      else if (pop_en)     beat_cnt <= beat_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend    <= 1'b0;
      base_q        <= '0;
      addr_cnt      <= '0;
      addr_offset_q <= '0;
      xfer_size_q   <= 64'(BURST_LENGTH_BYTE);
    end else begin
      if (end_conv)         flush_pend <= 1'b1;
      else if (conv_done_c) flush_pend <= 1'b0;
      if (start_burst) begin
        addr_offset_q <= base_q + addr_cnt * 64'(BURST_LENGTH_BYTE);
        xfer_size_q   <= 64'(beats_n) * 64'(DATA_WIDTH_BYTE);
      end
      if ((state == S_IDLE) && op_start) begin
        base_q   <= addr_base;
        addr_cnt <= '0;
      end else if (conv_done_c) begin
        addr_cnt <= '0;
      end else if ((state == S_WAIT) && wm.wmst_done) begin
        addr_cnt <= addr_cnt + 64'd1;
      end
    end
  end

`ifdef OUTPUT_BUFFER_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  wr_bytes <= '0;
    else if ((state == S_IDLE) && op_start)      wr_bytes <= '0;
    else if ((state == S_WAIT) && wm.wmst_done)  wr_bytes <= wr_bytes + xfer_size_q;
  end
`endif

endmodule

// File: tb/tb_output_buffer.sv
// Directed scenarios with random data and random tready for output_buffer; a responder plays the write master.
`timescale 1ns/1ps
module tb_output_buffer;
  localparam int          DW          = 512;
  localparam int          BL          = 64;
  localparam int          WB          = DW/8;
  localparam logic [63:0] BURST_BYTES = 64'd4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push_req = 1'b0;
  logic          op_start = 1'b0;
  logic          end_conv = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic [63:0]   addr_base = '0;
  logic          stall, conv_done;
  logic [1:0]    dbg_state;
`ifdef OUTPUT_BUFFER_STAT_EN
  logic [63:0]   wr_bytes;
`endif

  output_buffer_if #(.DATA_WIDTH(DW)) bus ();

  output_buffer #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_req  (push_req),
    .i_data    (i_data),
    .stall     (stall),
    .op_start  (op_start),
    .end_conv  (end_conv),
    .conv_done (conv_done),
    .addr_base (addr_base),
    .dbg_state (dbg_state),
`ifdef OUTPUT_BUFFER_STAT_EN
    .wr_bytes  (wr_bytes),
`endif
    .wm        (bus.master)
  );

  always #5 clk = ~clk;

  // Scoreboard and reference model state
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [63:0]   log_addr[$];
  logic [63:0]   log_size[$];
  int            words_in = 0;
  int            assigned = 0;
  int            burst_idx = 0;
  int            n_req = 0;
  int            n_conv = 0;
  logic [63:0]   base_m = '0;
  bit            busy = 0;
  bit            hold_tready = 0;
  bit            rand_tready = 0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: all start and end at posedge+1
  task automatic push_word(output bit acc);
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom();
    push_req = 1'b1;
    i_data   = d;
    @(negedge clk);
    acc = !stall;
    if (acc) begin
      exp_q.push_back(d);
      words_in++;
    end
    @(posedge clk); #1;
    push_req = 1'b0;
  endtask

  task automatic push_n(input int n, output int n_acc);
    bit acc;
    n_acc = 0;
    for (int i = 0; i < n; i++) begin
      push_word(acc);
      if (acc) n_acc++;
    end
  endtask

  task automatic start_op(input logic [63:0] base);
    op_start  = 1'b1;
    addr_base = base;
    base_m    = base;
    burst_idx = 0;
    @(posedge clk); #1;
    op_start  = 1'b0;
  endtask

  task automatic pulse_end();
    end_conv = 1'b1;
    @(posedge clk); #1;
    end_conv = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c = 0;
    while ((busy || exp_q.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_bit({tag, "_drained"}, c < budget, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_conv(input string tag, input int target, input int budget);
    int c = 0;
    while (n_conv < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_bit({tag, "_conv_seen"}, c < budget, 1'b1);
    @(posedge clk); #1;
  endtask

  // tready source
  initial begin
    forever begin
      @(posedge clk); #1;
      if (hold_tready)      bus.tready = 1'b0;
      else if (rand_tready) bus.tready = 1'($urandom_range(0, 1));
      else                  bus.tready = 1'b1;
    end
  end

  // Write-master responder: checks each request and its burst, then acknowledges
  initial begin : responder
    int            exp_beats, seen, budget, pending;
    logic [63:0]   a;
    logic [DW-1:0] d;
    bit            started;
    forever begin
      @(negedge clk);
      if (rst_n && bus.wmst_req) begin
        busy      = 1;
        pending   = words_in - assigned;
        exp_beats = (pending >= BL) ? BL : pending;
        assigned += exp_beats;
        a         = bus.addr_offset;
        log_addr.push_back(a);
        log_size.push_back(bus.xfer_size);
        n_req++;
        check64("req_addr", a, base_m + 64'(burst_idx) * BURST_BYTES);
        check64("req_size", bus.xfer_size, 64'(exp_beats) * 64'(WB));
        burst_idx++;
        seen = 0; budget = 0; started = 0;
        while (seen < exp_beats && budget < 4000) begin
          @(negedge clk);
          if (!rst_n) break;
          budget++;
          if (budget == 1) check_bit("req_pulse_width", bus.wmst_req, 1'b0);
          check64("addr_stable", bus.addr_offset, a);
          if (started) check_bit("tvalid_held", bus.tvalid, 1'b1);
          if (bus.tvalid) started = 1;
          if (bus.tvalid && bus.tready) begin
            seen++;
            check_bit("beat_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
              d = exp_q.pop_front();
              check_data("beat_data", bus.tdata, d);
            end
          end
        end
        if (rst_n) begin
          check_bit("burst_complete", seen == exp_beats, 1'b1);
          @(negedge clk);
          check_bit("tvalid_after_burst", bus.tvalid, 1'b0);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          @(posedge clk); #1;
          bus.wmst_done = 1'b1;
          @(posedge clk); #1;
          bus.wmst_done = 1'b0;
        end
        busy = 0;
      end
    end
  end

  // conv_done monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && conv_done) begin
        n_conv++;
        check64("conv_done_drained", 64'(words_in - assigned), 64'd0);
        burst_idx = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int r0, c0, n_acc;
    bit acc;
    bus.wmst_done = 1'b0;
    bus.tready    = 1'b1;

    // Reset values
    repeat (3) @(posedge clk); #1;
    check_bit("rst_stall", stall, 1'b0);
    check_bit("rst_conv_done", conv_done, 1'b0);
    check_bit("rst_wmst_req", bus.wmst_req, 1'b0);
    check_bit("rst_tvalid", bus.tvalid, 1'b0);
    check64("rst_addr_offset", bus.addr_offset, 64'd0);
    check64("rst_xfer_size", bus.xfer_size, BURST_BYTES);
`ifdef OUTPUT_BUFFER_STAT_EN
    check64("rst_wr_bytes", wr_bytes, 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One full burst
    r0 = n_req;
    start_op(64'h1000);
    push_n(64, n_acc);
    check64("s1_accepted", 64'(n_acc), 64'd64);
    wait_idle("s1", 1000);
    check64("s1_nreq", 64'(n_req - r0), 64'd1);
    check64("s1_addr", log_addr[r0], 64'h1000);
    check64("s1_size", log_size[r0], 64'd4096);
    check_bit("s1_tvalid_idle", bus.tvalid, 1'b0);
    check_bit("s1_wmst_req_idle", bus.wmst_req, 1'b0);
`ifdef OUTPUT_BUFFER_STAT_EN
    check64("s1_wr_bytes", wr_bytes, 64'd4096);
`endif

    // 150 words plus flush, random tready
    r0 = n_req; c0 = n_conv;
    rand_tready = 1;
    start_op(64'h1000);
    push_n(150, n_acc);
    pulse_end();
    wait_conv("s2", c0 + 1, 4000);
    wait_idle("s2", 1000);
    repeat (5) @(posedge clk); #1;
    check64("s2_nconv", 64'(n_conv - c0), 64'd1);
    check64("s2_nreq", 64'(n_req - r0), 64'd3);
    check64("s2_addr0", log_addr[r0], 64'h1000);
    check64("s2_addr1", log_addr[r0+1], 64'h2000);
    check64("s2_addr2", log_addr[r0+2], 64'h3000);
    check64("s2_size0", log_size[r0], 64'd4096);
    check64("s2_size1", log_size[r0+1], 64'd4096);
    check64("s2_size2", log_size[r0+2], 64'd1408);
    rand_tready = 0;

    // Fill to full with tready held low
    r0 = n_req;
    hold_tready = 1;
    start_op(64'h8000_0000);
    push_n(127, n_acc);
    check64("s3_accept_127", 64'(n_acc), 64'd127);
    check_bit("s3_stall_before_128", stall, 1'b0);
    push_word(acc);
    check_bit("s3_accept_128", acc, 1'b1);
    check_bit("s3_stall_at_128", stall, 1'b1);
    push_word(acc);
    check_bit("s3_reject_129", acc, 1'b0);
    check_bit("s3_stall_held", stall, 1'b1);
    hold_tready = 0;
    wait_idle("s3", 2000);
    check64("s3_nreq", 64'(n_req - r0), 64'd2);
    check64("s3_addr0", log_addr[r0], 64'h8000_0000);
    check64("s3_addr1", log_addr[r0+1], 64'h8000_1000);
    check_bit("s3_stall_released", stall, 1'b0);

    // end_conv with an empty FIFO
    r0 = n_req; c0 = n_conv;
    end_conv = 1'b1;
    @(negedge clk);
    check_bit("s4_conv_same_cycle", conv_done, 1'b0);
    @(posedge clk); #1;
    end_conv = 1'b0;
    @(negedge clk);
    check_bit("s4_conv_next_cycle", conv_done, 1'b1);
    @(negedge clk);
    check_bit("s4_conv_one_pulse", conv_done, 1'b0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk); #1;
    check64("s4_no_req", 64'(n_req - r0), 64'd0);
    check64("s4_nconv", 64'(n_conv - c0), 64'd1);
    start_op(64'h4000);
    push_n(64, n_acc);
    wait_idle("s4", 1000);
    check64("s4_addr", log_addr[r0], 64'h4000);
    check64("s4_size", log_size[r0], 64'd4096);

    // Reset during a stalled burst
    r0 = n_req;
    hold_tready = 1;
    start_op(64'h1000);
    push_n(64, n_acc);
    c0 = 0;
    while (n_req == r0 && c0 < 500) begin
      @(negedge clk);
      c0++;
    end
    check_bit("s5_req_seen", n_req > r0, 1'b1);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_bit("s5_rst_tvalid", bus.tvalid, 1'b0);
    check_bit("s5_rst_wmst_req", bus.wmst_req, 1'b0);
    check_bit("s5_rst_stall", stall, 1'b0);
    check_bit("s5_rst_conv_done", conv_done, 1'b0);
    check64("s5_rst_addr_offset", bus.addr_offset, 64'd0);
    check64("s5_rst_xfer_size", bus.xfer_size, BURST_BYTES);
    exp_q.delete();
    words_in = 0; assigned = 0; burst_idx = 0;
    hold_tready = 0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    r0 = n_req;
    start_op(64'h1000);
    push_n(64, n_acc);
    wait_idle("s5", 1000);
    check64("s5_nreq", 64'(n_req - r0), 64'd1);
    check64("s5_addr", log_addr[r0], 64'h1000);
    check64("s5_size", log_size[r0], 64'd4096);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
